// File: rtl/rr_arb_sel8_pkg.sv
// Shared constants for the eight-way round-robin arbiter slice.
// Source count and index width used by arbiter and selector.
package rr_arb_sel8_pkg;

    localparam int NUM_SRC = 8;
    localparam int SRC_W   = 3;

    typedef logic [SRC_W-1:0] src_t;

endpackage

// File: rtl/mux8.sv
// Eight-way payload selector.
// Select codes 8..15 are never produced upstream; they return zero.
module mux8
    import rr_arb_sel8_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [SRC_W:0]   sel,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    output logic [WIDTH-1:0] y
);

    // pick one source payload by select code
    always_comb begin
        y = '0;
        case (sel)
            4'd0:    y = d0;
            4'd1:    y = d1;
            4'd2:    y = d2;
            4'd3:    y = d3;
            4'd4:    y = d4;
            4'd5:    y = d5;
            4'd6:    y = d6;
            4'd7:    y = d7;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rr_arb_sel8.sv
// Eight-source round-robin arbiter with a registered output slot.
// Winner payload is captured through mux8 into a valid/ready slot.
module rr_arb_sel8
    import rr_arb_sel8_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req_valid,
    output logic [NUM_SRC-1:0] req_ready,
    input  logic [WIDTH-1:0]   d0,
    input  logic [WIDTH-1:0]   d1,
    input  logic [WIDTH-1:0]   d2,
    input  logic [WIDTH-1:0]   d3,
    input  logic [WIDTH-1:0]   d4,
    input  logic [WIDTH-1:0]   d5,
    input  logic [WIDTH-1:0]   d6,
    input  logic [WIDTH-1:0]   d7,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output src_t               out_src
);

    src_t                      ptr;
    src_t                      w;
    logic                      any_req;
    logic                      load_en;
    logic                      accept;
    logic [2*NUM_SRC-1:0]      dbl;
    logic [2*NUM_SRC-1:0]      masked;
    logic [WIDTH-1:0]          mux_y;

    assign any_req = |req_valid;
    assign load_en = ~out_valid | out_ready;
    assign accept  = load_en & any_req;

    // Bits below ptr in the doubled vector are masked off, so the lowest
    // surviving bit is the first requester at or after ptr, circularly.
    assign dbl    = {req_valid, req_valid};
    assign masked = dbl & (16'hFFFF << ptr);

    // lowest set bit of the masked vector; its index mod 8 is the winner
    always_comb begin
        w = '0;
        for (int i = 2*NUM_SRC-1; i >= 0; i--) begin
            if (masked[i]) begin
                w = src_t'(i);
            end
        end
    end

    // one-hot grant only when the payload is captured this edge
    always_comb begin
        req_ready = '0;
        if (accept && !rst) begin
            req_ready = 8'b1 << w;
        end
    end

    mux8 #(
        .WIDTH (WIDTH)
    ) u_mux8 (
        .sel (4'({1'b0, w})),
        .d0  (d0),
        .d1  (d1),
        .d2  (d2),
        .d3  (d3),
        .d4  (d4),
        .d5  (d5),
        .d6  (d6),
        .d7  (d7),
        .y   (mux_y)
    );

    // output slot and pointer: refill, drain, or hold when stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (load_en) begin
            if (any_req) begin
                out_valid <= 1'b1;
                out_data  <= mux_y;
                out_src   <= w;
                ptr       <= w + 3'd1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
